// File: rtl/trn_rr_arbiter.sv
// N-channel arbiter for the shared TRN endpoint interface: round-robin or fixed-priority offers,
// held with a timeout, followed by a configurable idle gap; flags foreign drive as a sticky error.
module trn_rr_arbiter #(
    parameter int unsigned N_CH       = 4,
    parameter int unsigned ID_W       = 2,
    parameter int unsigned MODE       = 0,
    parameter int unsigned OFFER_TO   = 64,
    parameter int unsigned GAP_CYCLES = 1
) (
    input  logic            trn_clk,
    input  logic            reset,
    input  logic [N_CH-1:0] req,
    input  logic [N_CH-1:0] driven,
    output logic [N_CH-1:0] turn,
    output logic [ID_W-1:0] grant_id,
    output logic            busy,
    output logic            timeout_pulse,
    output logic            protocol_err
);

    typedef enum logic [1:0] {StIdle, StOffer, StBusy, StGap} state_e;

    // With no gap configured, a release lands directly in IDLE.
    localparam state_e RelState = (GAP_CYCLES == 0) ? StIdle : StGap;

    state_e          state_q;
    logic [ID_W-1:0] last_q;
    logic [15:0]     wait_q;
    logic [3:0]      gap_q;

    logic [ID_W-1:0] pick;
    logic            pick_vld;
    logic            own_drv;
    logic            other_drv;

    always_comb begin
        int unsigned     idx;
        logic [ID_W-1:0] ix;
        pick     = '0;
        pick_vld = 1'b0;
        idx      = 0;
        ix       = '0;
        for (int unsigned i = 0; i < N_CH; i++) begin
            if (MODE == 1) begin
                idx = i;
            end else begin
                idx = (32'(last_q) + i + 1) % N_CH;
            end
            ix = ID_W'(idx);
            if (!pick_vld && req[ix]) begin
                pick_vld = 1'b1;
                pick     = ix;
            end
        end
    end

    // grant_id holds the channel currently owning the offer/grant.
    assign own_drv   = driven[grant_id];
    assign other_drv = |(driven & ~(N_CH'(1) << grant_id));

    always_ff @(posedge trn_clk) begin
        if (reset) begin
            state_q       <= StIdle;
            last_q        <= ID_W'(N_CH - 1);
            wait_q        <= '0;
            gap_q         <= '0;
            turn          <= '0;
            grant_id      <= '0;
            busy          <= 1'b0;
            timeout_pulse <= 1'b0;
            protocol_err  <= 1'b0;
        end else begin
            timeout_pulse <= 1'b0;
            if ((state_q == StOffer || state_q == StBusy) && other_drv) begin
                protocol_err <= 1'b1;
            end
            case (state_q)
                StIdle: begin
                    if (driven == '0 && pick_vld) begin
                        turn     <= N_CH'(1) << pick;
                        grant_id <= pick;
                        busy     <= 1'b1;
                        wait_q   <= '0;
                        state_q  <= StOffer;
                    end
                end
                StOffer: begin
                    if (own_drv) begin
                        turn    <= '0;
                        last_q  <= grant_id;
                        state_q <= StBusy;
                    end else if (!req[grant_id]) begin
                        turn    <= '0;
                        last_q  <= grant_id;
                        busy    <= 1'b0;
                        gap_q   <= '0;
                        state_q <= RelState;
                    end else if (wait_q == 16'(OFFER_TO - 1)) begin
                        turn          <= '0;
                        last_q        <= grant_id;
                        busy          <= 1'b0;
                        timeout_pulse <= 1'b1;
                        gap_q         <= '0;
                        state_q       <= RelState;
                    end else if (wait_q != 16'hFFFF) begin
                        wait_q <= wait_q + 16'd1;
                    end
                end
                StBusy: begin
                    if (!own_drv) begin
                        busy    <= 1'b0;
                        gap_q   <= '0;
                        state_q <= RelState;
                    end
                end
                StGap: begin
                    if (gap_q == 4'(GAP_CYCLES - 1)) begin
                        state_q <= StIdle;
                    end else begin
                        gap_q <= gap_q + 4'd1;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_trn_rr_arbiter.sv
// Directed bench for trn_rr_arbiter: a round-robin instance (short offer timeout) and a
// fixed-priority instance, each checked against hand-computed expectations.
module tb_trn_rr_arbiter;

    logic       trn_clk = 1'b0;
    logic       reset;
    logic [3:0] req, driven, turn;
    logic [1:0] grant_id;
    logic       busy, timeout_pulse, protocol_err;
    logic [3:0] req_fp, driven_fp, turn_fp;
    logic [1:0] grant_id_fp;
    logic       busy_fp, timeout_pulse_fp, protocol_err_fp;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 trn_clk = ~trn_clk;

    trn_rr_arbiter #(
        .N_CH(4), .ID_W(2), .MODE(0), .OFFER_TO(8), .GAP_CYCLES(1)
    ) u_rr (
        .trn_clk(trn_clk), .reset(reset), .req(req), .driven(driven), .turn(turn),
        .grant_id(grant_id), .busy(busy), .timeout_pulse(timeout_pulse),
        .protocol_err(protocol_err)
    );

    trn_rr_arbiter #(
        .N_CH(4), .ID_W(2), .MODE(1), .OFFER_TO(64), .GAP_CYCLES(1)
    ) u_fp (
        .trn_clk(trn_clk), .reset(reset), .req(req_fp), .driven(driven_fp), .turn(turn_fp),
        .grant_id(grant_id_fp), .busy(busy_fp), .timeout_pulse(timeout_pulse_fp),
        .protocol_err(protocol_err_fp)
    );

    task automatic step();
        @(posedge trn_clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic do_reset();
        reset     = 1'b1;
        req       = '0;
        driven    = '0;
        req_fp    = '0;
        driven_fp = '0;
        step();
        step();
        reset = 1'b0;
    endtask

    initial begin
        int n;

        // Reset values
        do_reset();
        check("rst_turn", turn, 0);
        check("rst_id", grant_id, 0);
        check("rst_busy", busy, 0);
        check("rst_to", timeout_pulse, 0);
        check("rst_err", protocol_err, 0);

        // Single channel: offer, drive for 10 cycles, release, regrant after gap
        req = 4'b0001;
        step();
        check("t1_turn", turn, 4'b0001);
        check("t1_busy", busy, 1);
        step();
        step();
        check("t1_hold", turn, 4'b0001);
        driven = 4'b0001;
        step();
        check("t1_drop", turn, 0);
        check("t1_busy_drv", busy, 1);
        for (int i = 0; i < 9; i++) step();
        check("t1_busy_end", busy, 1);
        driven = '0;
        step();
        check("t1_rel_busy", busy, 0);
        check("t1_rel_turn", turn, 0);
        step();
        check("t1_gap_turn", turn, 0);
        step();
        check("t1_regrant", turn, 4'b0001);

        // Stray drive in IDLE blocks the grant
        do_reset();
        req    = 4'b0001;
        driven = 4'b0010;
        step();
        check("stray_turn", turn, 0);
        check("stray_err", protocol_err, 0);
        driven = '0;
        step();
        check("stray_grant", turn, 4'b0001);

        // Request withdrawn during an offer
        do_reset();
        req = 4'b0010;
        step();
        check("rd_turn", turn, 4'b0010);
        check("rd_id", grant_id, 1);
        step();
        step();
        req = '0;
        step();
        check("rd_wd_turn", turn, 0);
        check("rd_wd_to", timeout_pulse, 0);
        check("rd_wd_busy", busy, 0);
        req = 4'b0010;
        step();
        check("rd_gap", turn, 0);
        step();
        check("rd_regrant", turn, 4'b0010);

        // Offer timeout (OFFER_TO = 8)
        do_reset();
        req = 4'b0100;
        for (int i = 0; i < 8; i++) begin
            step();
            check("to_hold", turn, 4'b0100);
            check("to_nopulse", timeout_pulse, 0);
        end
        step();
        check("to_wd_turn", turn, 0);
        check("to_pulse", timeout_pulse, 1);
        step();
        check("to_pulse_end", timeout_pulse, 0);
        check("to_gap", turn, 0);
        step();
        check("to_reoffer", turn, 4'b0100);
        check("to_reoffer_id", grant_id, 2);

        // Round-robin fairness, all requesting
        do_reset();
        req = 4'b1111;
        for (int g = 0; g < 6; g++) begin
            n = 0;
            while (turn == '0 && n < 20) begin
                step();
                n++;
            end
            check("rr_wait", 32'(n < 20), 1);
            check("rr_id", 32'(grant_id), 32'(g % 4));
            check("rr_turn", 32'(turn), 32'(1 << (g % 4)));
            driven = turn;
            step();
            step();
            driven = '0;
        end
        req = '0;

        // Fixed priority, all requesting
        do_reset();
        req_fp = 4'b1111;
        for (int g = 0; g < 3; g++) begin
            n = 0;
            while (turn_fp == '0 && n < 20) begin
                step();
                n++;
            end
            check("fp_wait", 32'(n < 20), 1);
            check("fp_id", grant_id_fp, 0);
            check("fp_turn", turn_fp, 4'b0001);
            driven_fp = turn_fp;
            step();
            step();
            driven_fp = '0;
        end
        req_fp = '0;

        // Protocol error while channel 0 is busy
        do_reset();
        req = 4'b0001;
        step();
        driven = 4'b0001;
        step();
        check("pe_busy", busy, 1);
        check("pe_clean", protocol_err, 0);
        driven = 4'b1001;
        step();
        check("pe_set", protocol_err, 1);
        check("pe_busy_kept", busy, 1);
        driven = 4'b0001;
        step();
        check("pe_sticky", protocol_err, 1);
        check("pe_id", grant_id, 0);
        driven = '0;
        req    = '0;
        step();
        check("pe_release", busy, 0);
        step();
        check("pe_sticky_idle", protocol_err, 1);

        // Reset while busy, then first grant with req = 1010
        do_reset();
        req = 4'b0100;
        step();
        check("rb_id", grant_id, 2);
        driven = 4'b0100;
        step();
        check("rb_busy", busy, 1);
        reset = 1'b1;
        step();
        check("rb_turn", turn, 0);
        check("rb_busy0", busy, 0);
        check("rb_id0", grant_id, 0);
        check("rb_to", timeout_pulse, 0);
        reset  = 1'b0;
        driven = '0;
        req    = 4'b1010;
        step();
        check("rb_first", turn, 4'b0010);
        check("rb_first_id", grant_id, 1);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
